// File: rtl/gin_issue_unit_if.sv
// rtl/gin_issue_unit_if.sv - packet-in and GIN bus handshake signals for gin_issue_unit
// Purpose: bundles the scheduler packet stream (in_*) and the GIN bus (gin_*).
// Ports (signals):
//   in_valid/in_tag/in_value -> issue unit, in_ready <- issue unit
//   gin_tag/gin_enable/gin_value <- issue unit, gin_ready -> issue unit
// Modports: master = issue unit side, slave = scheduler/controller side.
interface gin_issue_unit_if #(
  parameter int ID_LEN    = 4,
  parameter int VALUE_LEN = 32
);
  logic                 in_valid;
  logic [ID_LEN-1:0]    in_tag;
  logic [VALUE_LEN-1:0] in_value;
  logic                 in_ready;
  logic [ID_LEN-1:0]    gin_tag;
  logic                 gin_enable;
  logic [VALUE_LEN-1:0] gin_value;
  logic                 gin_ready;

  modport master (
    input  in_valid, in_tag, in_value, gin_ready,
    output in_ready, gin_tag, gin_enable, gin_value
  );

  modport slave (
    output in_valid, in_tag, in_value, gin_ready,
    input  in_ready, gin_tag, gin_enable, gin_value
  );
endinterface

// File: rtl/gin_issue_unit.sv
// rtl/gin_issue_unit.sv - GIN bus issue unit: packet FIFO, bus handshake, ID scan-chain driver
// Purpose: buffers (tag,value) packets and issues one per accepted GIN handshake;
//   in SCAN state drives the head of the controller set_id/id chain.
// Ports:
//   clk, rst (sync, active-high)
//   scan_start, scan_id_valid, scan_id -> ; scan_id_ready, set_id, id_out, scan_done <-
//   bus (gin_issue_unit_if.master): in_* packet stream and gin_* bus
//   busy, stall_err <-
// Optional feature: macro GIN_STALL_DET_EN enables the sticky stall watchdog;
//   undefined, stall_err is tied 0.
module gin_issue_unit #(
  parameter int ID_LEN      = 4,
  parameter int VALUE_LEN   = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int CHAIN_LEN   = 12,
  parameter int STALL_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_start,
  input  logic              scan_id_valid,
  input  logic [ID_LEN-1:0] scan_id,
  output logic              scan_id_ready,
  output logic              set_id,
  output logic [ID_LEN-1:0] id_out,
  output logic              scan_done,
  gin_issue_unit_if.master  bus,
  output logic              busy,
  output logic              stall_err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(CHAIN_LEN + 1);
  localparam int PKT_W = ID_LEN + VALUE_LEN;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [PKT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SC_W-1:0]  shift_cnt;
  logic             done_q;
  logic             empty, full, push, pop, shift;
  logic [PKT_W-1:0] head;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign head  = mem[rd_ptr];

  // Handshake outputs are combinational but gated by rst so that all
  // outputs read 0 while reset is held.
  assign bus.in_ready   = !rst && (state == IDLE) && !full;
  assign bus.gin_enable = !rst && (state == IDLE) && !empty;
  assign {bus.gin_tag, bus.gin_value} = bus.gin_enable ? head : '0;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.gin_enable && bus.gin_ready;

  assign shift         = !rst && (state == SCAN) && scan_id_valid;
  assign set_id        = shift;
  assign scan_id_ready = shift;
  assign id_out        = (!rst && (state == SCAN)) ? scan_id : '0;
  assign scan_done     = done_q;
  assign busy          = !rst && ((state == SCAN) || !empty);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_tag, bus.in_value};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      shift_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      case (state)
        IDLE: begin
          // A scan request while packets are queued is dropped, not deferred.
          if (scan_start && empty) state <= SCAN;
        end
        SCAN: begin
          if (shift) begin
            if (shift_cnt == SC_W'(CHAIN_LEN - 1)) begin
              shift_cnt <= '0;
              done_q    <= 1'b1;
              state     <= IDLE;
            end else begin
              shift_cnt <= shift_cnt + SC_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GIN_STALL_DET_EN
  localparam int STW = $clog2(STALL_LIMIT + 1);
  logic [STW-1:0] stall_cnt;
  logic           stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_q   <= 1'b0;
    end else if (bus.gin_enable && !bus.gin_ready) begin
      if (stall_cnt != STW'(STALL_LIMIT)) stall_cnt <= stall_cnt + STW'(1);
      if (stall_cnt == STW'(STALL_LIMIT - 1)) stall_q <= 1'b1;
    end else if (pop || empty) begin
      stall_cnt <= '0;
    end
  end

  assign stall_err = stall_q;
`else
  assign stall_err = 1'b0;
`endif
endmodule
